// File: rtl/axis_seq_divider.sv
// Sequential radix-2 restoring divider with independent AXI-Stream dividend/divisor
// channels and a single {remainder, quotient} result stream.
module axis_seq_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 aclken,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  input  logic                 m_axis_dout_tready,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]   dividend_hold_reg, divisor_hold_reg;
  logic               dividend_held_reg, divisor_held_reg;
  logic [CW-1:0]      count_reg;
  logic               iter_done_reg;
  logic [WIDTH-1:0]   rem_reg, quo_reg, div_mag_reg;
  logic               quo_neg_reg, rem_neg_reg, div_zero_reg;
  logic [2*WIDTH-1:0] dout_reg;

  logic               dividend_fire, divisor_fire, start;
  logic               dividend_neg, divisor_neg;
  logic [WIDTH:0]     shifted, diff;
  logic               trial_ok;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return (SIGNED && v[WIDTH-1]) ? -v : v;
  endfunction

  assign s_axis_dividend_tready = (state_reg == IDLE) && !dividend_held_reg;
  assign s_axis_divisor_tready  = (state_reg == IDLE) && !divisor_held_reg;
  assign dividend_fire = aclken && s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign divisor_fire  = aclken && s_axis_divisor_tvalid && s_axis_divisor_tready;
  assign start         = (state_reg == IDLE) && dividend_held_reg && divisor_held_reg;

  assign dividend_neg = SIGNED && dividend_hold_reg[WIDTH-1];
  assign divisor_neg  = SIGNED && divisor_hold_reg[WIDTH-1];

  // Trial subtraction; the extra top bit of the shifted partial remainder can exceed the divisor range.
  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign diff     = shifted - {1'b0, div_mag_reg};
  assign trial_ok = shifted[WIDTH] | ~diff[WIDTH];

  assign quo_fix = div_zero_reg ? '1 : (quo_neg_reg ? -quo_reg : quo_reg);
  assign rem_fix = rem_neg_reg ? -rem_reg : rem_reg;

  assign m_axis_dout_tvalid = (state_reg == DONE);
  assign m_axis_dout_tdata  = dout_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else if (aclken) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (iter_done_reg) state_next = DONE;
      DONE:    if (m_axis_dout_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dividend_hold_reg <= '0;
      divisor_hold_reg  <= '0;
      dividend_held_reg <= 1'b0;
      divisor_held_reg  <= 1'b0;
    end else if (aclken) begin
      if (start) begin
        dividend_held_reg <= 1'b0;
        divisor_held_reg  <= 1'b0;
      end else begin
        if (dividend_fire) begin
          dividend_hold_reg <= s_axis_dividend_tdata;
          dividend_held_reg <= 1'b1;
        end
        if (divisor_fire) begin
          divisor_hold_reg <= s_axis_divisor_tdata;
          divisor_held_reg <= 1'b1;
        end
      end
    end
  end

  // Iterations run while iter_done_reg is low; the following CALC edge only applies sign correction.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_reg     <= '0;
      iter_done_reg <= 1'b0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      div_mag_reg   <= '0;
      quo_neg_reg   <= 1'b0;
      rem_neg_reg   <= 1'b0;
      div_zero_reg  <= 1'b0;
      dout_reg      <= '0;
    end else if (aclken) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            quo_reg       <= magnitude(dividend_hold_reg);
            rem_reg       <= '0;
            div_mag_reg   <= magnitude(divisor_hold_reg);
            quo_neg_reg   <= dividend_neg ^ divisor_neg;
            rem_neg_reg   <= dividend_neg;
            div_zero_reg  <= (divisor_hold_reg == '0);
            count_reg     <= CW'(WIDTH - 1);
            iter_done_reg <= 1'b0;
          end
        end
        CALC: begin
          if (!iter_done_reg) begin
            rem_reg <= trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], trial_ok};
            if (count_reg == '0) begin
              iter_done_reg <= 1'b1;
            end else begin
              count_reg <= count_reg - 1'b1;
            end
          end else begin
            dout_reg <= {rem_fix, quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_seq_divider.sv
// Scoreboard bench: a signed and an unsigned divider share stimulus; a monitor checks
// result data, latency in clock cycles, output hold under backpressure and input tready.
module tb_axis_seq_divider;

  localparam int W = 32;

  logic          aclk = 1'b0;
  logic          aresetn, aclken;
  logic          dvd_valid, dvs_valid, dout_ready;
  logic [W-1:0]  dvd_data, dvs_data;

  logic          s_dvd_rdy, s_dvs_rdy, s_valid;
  logic [2*W-1:0] s_data;
  logic          u_dvd_rdy, u_dvs_rdy, u_valid;
  logic [2*W-1:0] u_data;

  logic [1:0]     mvalid;
  logic [2*W-1:0] mdata [2];
  logic [1:0]     in_rdy [2];

  typedef struct {
    logic [2*W-1:0] data;
    int             edge_n;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int outputs_seen = 0;

  axis_seq_divider #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(s_dvd_rdy),
    .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(s_dvs_rdy),
    .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(s_valid), .m_axis_dout_tready(dout_ready),
    .m_axis_dout_tdata(s_data)
  );

  axis_seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(u_dvd_rdy),
    .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(u_dvs_rdy),
    .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(u_valid), .m_axis_dout_tready(dout_ready),
    .m_axis_dout_tdata(u_data)
  );

  assign mvalid    = {u_valid, s_valid};
  assign mdata[0]  = s_data;
  assign mdata[1]  = u_data;
  assign in_rdy[0] = {s_dvd_rdy, s_dvs_rdy};
  assign in_rdy[1] = {u_dvd_rdy, u_dvs_rdy};

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // which: bit0 = dividend channel, bit1 = divisor channel
  function automatic bit ready_ok(input int which);
    bit ok = 1'b1;
    if (which[0]) ok = ok && s_dvd_rdy && u_dvd_rdy;
    if (which[1]) ok = ok && s_dvs_rdy && u_dvs_rdy;
    return ok && aclken;
  endfunction

  task automatic wait_ready(input int which, output int hs);
    int n = 0;
    while (!ready_ok(which) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!ready_ok(which)) begin
      checks++;
      fails++;
      $display("FAIL handshake_timeout: got tready low for %0d cycles, required tready high", n);
    end
    hs = cyc + 1;
    @(negedge aclk);
    if (which[0]) dvd_valid = 1'b0;
    if (which[1]) dvs_valid = 1'b0;
  endtask

  // lead > 0: divisor handshakes lead cycles before dividend; lead < 0: dividend first.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int lead,
                      input logic [2*W-1:0] es, input logic [2*W-1:0] eu,
                      input int extra, input bit push);
    int h1, hs;
    @(negedge aclk);
    dvd_data = a;
    dvs_data = b;
    if (lead == 0) begin
      dvd_valid = 1'b1;
      dvs_valid = 1'b1;
      wait_ready(3, hs);
    end else if (lead > 0) begin
      dvs_valid = 1'b1;
      wait_ready(2, h1);
      repeat (lead - 1) @(negedge aclk);
      dvd_valid = 1'b1;
      wait_ready(1, hs);
    end else begin
      dvd_valid = 1'b1;
      wait_ready(1, h1);
      repeat (-lead - 1) @(negedge aclk);
      dvs_valid = 1'b1;
      wait_ready(2, hs);
    end
    if (push) begin
      q_s.push_back('{data: es, edge_n: hs + W + 2 + extra});
      q_u.push_back('{data: eu, edge_n: hs + W + 2 + extra});
    end
    $display("issue %h / %h lead=%0d later_hs_cycle=%0d expect_s=%h expect_u=%h",
             a, b, lead, hs, es, eu);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (q_s.size() != 0 || q_u.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL result_timeout: got %0d/%0d results pending, required 0", q_s.size(), q_u.size());
      q_s.delete();
      q_u.delete();
    end
    @(negedge aclk);
  endtask

  task automatic check_reset_state();
    check("rst_valid_s", 64'(s_valid), 64'd0);
    check("rst_valid_u", 64'(u_valid), 64'd0);
    check("rst_data_s", s_data, 64'd0);
    check("rst_data_u", u_data, 64'd0);
    check("rst_tready_s", 64'({s_dvd_rdy, s_dvs_rdy}), 64'd3);
    check("rst_tready_u", 64'({u_dvd_rdy, u_dvs_rdy}), 64'd3);
  endtask

  initial begin : monitor
    bit             prev_v [2];
    logic [2*W-1:0] held [2];
    exp_t           e;
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
        continue;
      end
      for (int d = 0; d < 2; d++) begin
        if (mvalid[d]) begin
          if (!prev_v[d]) begin
            outputs_seen++;
            if ((d == 0 && q_s.size() == 0) || (d == 1 && q_u.size() == 0)) begin
              checks++;
              fails++;
              $display("FAIL unexpected_output dut%0d: got tvalid with %h, required no output", d, mdata[d]);
            end else begin
              if (d == 0) e = q_s.pop_front();
              else        e = q_u.pop_front();
              check($sformatf("result_dut%0d", d), mdata[d], e.data);
              check($sformatf("latency_dut%0d", d), 64'(cyc), 64'(e.edge_n));
              $display("result dut%0d data=%h cycle=%0d", d, mdata[d], cyc);
            end
            held[d] = mdata[d];
          end else begin
            check($sformatf("hold_data_dut%0d", d), mdata[d], held[d]);
          end
          check($sformatf("in_tready_low_dut%0d", d), 64'(in_rdy[d]), 64'd0);
        end
        prev_v[d] = mvalid[d];
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int seen0;
    int n;
    aresetn    = 1'b0;
    aclken     = 1'b0;
    dvd_valid  = 1'b0;
    dvs_valid  = 1'b0;
    dvd_data   = '0;
    dvs_data   = '0;
    dout_ready = 1'b1;
    repeat (2) @(negedge aclk);
    check_reset_state();
    aresetn = 1'b1;
    aclken  = 1'b1;

    send(32'd100, 32'd7, 0, {32'h2, 32'hE}, {32'h2, 32'hE}, 0, 1'b1);
    wait_done();
    send(32'hFFFFFFF9, 32'd2, 5, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h1, 32'h7FFFFFFC}, 0, 1'b1);
    wait_done();
    send(32'd7, 32'hFFFFFFFD, -3, {32'h1, 32'hFFFFFFFE}, {32'h7, 32'h0}, 0, 1'b1);
    wait_done();
    send(32'h80000000, 32'hFFFFFFFF, 0, {32'h0, 32'h80000000}, {32'h80000000, 32'h0}, 0, 1'b1);
    wait_done();
    send(32'h12345678, 32'h0, 0, {32'h12345678, 32'hFFFFFFFF}, {32'h12345678, 32'hFFFFFFFF}, 0, 1'b1);
    wait_done();
    send(32'hFFFFFFFF, 32'd2, 0, {32'hFFFFFFFF, 32'h0}, {32'h1, 32'h7FFFFFFF}, 0, 1'b1);
    wait_done();

    // backpressure: hold the result for 10 cycles
    dout_ready = 1'b0;
    send(32'd1000, 32'd33, 0, {32'hA, 32'h1E}, {32'hA, 32'h1E}, 0, 1'b1);
    n = 0;
    while (!s_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    repeat (10) @(negedge aclk);
    dout_ready = 1'b1;
    wait_done();

    // clock-enable gap of 3 cycles mid-CALC
    send(32'hFFFFFF9C, 32'd7, 0, {32'hFFFFFFFE, 32'hFFFFFFF2}, {32'h2, 32'h24924916}, 3, 1'b1);
    repeat (10) @(negedge aclk);
    aclken = 1'b0;
    repeat (3) @(negedge aclk);
    aclken = 1'b1;
    wait_done();

    // reset mid-CALC discards the operation
    send(32'h7FFFFFFF, 32'd5, 0, '0, '0, 0, 1'b0);
    repeat (10) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_reset_state();
    @(negedge aclk);
    aresetn = 1'b1;
    seen0 = outputs_seen;
    repeat (40) @(negedge aclk);
    check("no_output_after_abort", 64'(outputs_seen), 64'(seen0));

    send(32'd9, 32'd3, 0, {32'h0, 32'h3}, {32'h0, 32'h3}, 0, 1'b1);
    wait_done();
    repeat (3) @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
